// File: rtl/dp_pkg.sv
// Shared encodings for the multicycle datapath: ALU ops, ALU-B selects, instruction fields, sign extension.
package dp_pkg;

    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned OPC_W     = 6;
    localparam int unsigned REG_IDX_W = 2;
    localparam int unsigned IMM_W     = 6;
    localparam int unsigned SEXT_W    = 64;

    typedef enum logic [1:0] {
        ALU_AND = 2'b00,
        ALU_OR  = 2'b01,
        ALU_ADD = 2'b10,
        ALU_SUB = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        SELB_BREG = 2'b00,
        SELB_IMM  = 2'b01,
        SELB_ONE  = 2'b10,
        SELB_BR   = 2'b11
    } selalub_e;

    // Instruction layout: opcode[15:10], ra[9:8], rb[7:6], imm[5:0]
    typedef struct packed {
        logic [OPC_W-1:0]     opcode;
        logic [REG_IDX_W-1:0] ra;
        logic [REG_IDX_W-1:0] rb;
        logic [IMM_W-1:0]     imm;
    } instr_t;

    function automatic logic [SEXT_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(SEXT_W - IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/dp_regfile.sv
// Register file: NREG x DATA_W, two async read ports, one write port.
// With DP_R0_ZERO_EN defined, r0 reads as zero and writes to it are dropped.
module dp_regfile
    import dp_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 4,
    parameter int unsigned IDX_W  = REG_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [IDX_W-1:0]  raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic              wr_en;

    always_comb begin
        wr_en = we_i;
`ifdef DP_R0_ZERO_EN
        wr_en = we_i && (waddr_i != '0);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = regs_q[raddr_a_i];
        rdata_b_o = regs_q[raddr_b_i];
`ifdef DP_R0_ZERO_EN
        if (raddr_a_i == '0) rdata_a_o = '0;
        if (raddr_b_i == '0) rdata_b_o = '0;
`endif
    end

endmodule

// File: rtl/datapath_mc.sv
// Multicycle CPU datapath driven by the control FSM's strobes and selects.
// Optional DP_R0_ZERO_EN makes r0 a hardwired zero (handled in dp_regfile).
module datapath_mc
    import dp_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned NREG   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              writepc,
    input  logic              writeir,
    input  logic              writereg,
    input  logic              writemem,
    input  logic              writezero,
    input  logic              selalua,
    input  logic [1:0]        selalub,
    input  logic [1:0]        aluop,
    input  logic              selload,
    input  logic              selst,
    input  logic              selldst,
    output logic [5:0]        opcode,
    output logic              zero,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] a_q, b_q, aluout_q, mdr_q;

    instr_t            instr;
    logic [DATA_W-1:0] rd_a, rd_b, wb_data, imm_ext;
    logic [DATA_W-1:0] alu_a, alu_b, alu_y;

    assign instr   = instr_t'(ir_q[INSTR_W-1:0]);
    assign imm_ext = DATA_W'(sext_imm(instr.imm));
    assign wb_data = selldst ? mdr_q : aluout_q;

    dp_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .IDX_W  (REG_IDX_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we_i      (writereg),
        .waddr_i   (instr.ra),
        .wdata_i   (wb_data),
        .raddr_a_i (instr.ra),
        .rdata_a_o (rd_a),
        .raddr_b_i (instr.rb),
        .rdata_b_o (rd_b)
    );

    // Operand selection and ALU; both branch and immediate paths use the same sign-extended field
    always_comb begin
        alu_a = selalua ? DATA_W'(pc_q) : a_q;
        case (selalub_e'(selalub))
            SELB_BREG: alu_b = b_q;
            SELB_IMM:  alu_b = imm_ext;
            SELB_ONE:  alu_b = DATA_W'(1);
            SELB_BR:   alu_b = imm_ext;
            default:   alu_b = b_q;
        endcase
        case (aluop_e'(aluop))
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_ADD: alu_y = alu_a + alu_b;
            ALU_SUB: alu_y = alu_a - alu_b;
            default: alu_y = alu_a + alu_b;
        endcase
    end

    always_comb begin
        pc_d   = pc_q;
        ir_d   = ir_q;
        zero_d = zero_q;
        if (writepc)   pc_d   = alu_y[ADDR_W-1:0];
        if (writeir)   ir_d   = mem_rdata;
        if (writezero) zero_d = (alu_y == '0);
    end

    // Operand/result latches load every cycle; PC, IR and zero follow their strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= '0;
            ir_q     <= '0;
            zero_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            zero_q   <= zero_d;
            a_q      <= rd_a;
            b_q      <= rd_b;
            aluout_q <= alu_y;
            mdr_q    <= mem_rdata;
        end
    end

    assign opcode    = instr.opcode;
    assign zero      = zero_q;
    assign mem_addr  = selload ? aluout_q[ADDR_W-1:0] : pc_q;
    assign mem_wdata = selst ? a_q : b_q;
    assign mem_we    = writemem;

endmodule
